// File: rtl/bpsk_symbol_packer.sv
// Integrate-and-dump BPSK symbol slicer: sums SPS samples per symbol, slices on sign,
// and packs N two-bit symbol codes into one word offered over a valid/ready handshake.
module bpsk_symbol_packer #(
    parameter int N   = 8,
    parameter int SPS = 16,
    parameter int SW  = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [SW-1:0] sample_in,
    input  logic                 sample_valid,
    input  logic                 sync,
    output logic [2*N-1:0]       word_out,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 overflow
);

    localparam int CW  = $clog2(SPS);
    localparam int AW  = SW + CW;
    localparam int SCW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    samp_cnt_q, samp_cnt_d;
    logic [SCW-1:0]   sym_cnt_q, sym_cnt_d;
    logic [2*N-1:0]   pack_q, pack_d;
    logic [2*N-1:0]   word_q, word_d;
    logic             overflow_q, overflow_d;

    logic [AW-1:0]    sample_ext_s;
    logic [AW-1:0]    sum_s;
    logic [1:0]       code_s;
    logic             sym_done_s;
    logic             word_done_s;
    logic             load_s;
    logic [2*N-1:0]   pack_full_s;

    // Symbol decision, pack-slot insert and next-state selection.
    always_comb begin
        sample_ext_s = {{CW{sample_in[SW-1]}}, sample_in};
        sum_s        = acc_q + sample_ext_s;
        code_s       = sum_s[AW-1] ? 2'b10 : 2'b01;
        // A sync pulse reframes, so a final sample coinciding with it starts a new symbol.
        sym_done_s   = sample_valid && !sync && (samp_cnt_q == CW'(SPS - 1));
        word_done_s  = sym_done_s && (sym_cnt_q == SCW'(N - 1));

        pack_full_s = pack_q;
        for (int k = 0; k < N; k++) begin
            if (sym_cnt_q == SCW'(k)) begin
                pack_full_s[2*k +: 2] = code_s;
            end else begin
                pack_full_s[2*k +: 2] = pack_q[2*k +: 2];
            end
        end

        acc_d      = acc_q;
        samp_cnt_d = samp_cnt_q;
        sym_cnt_d  = sym_cnt_q;
        pack_d     = pack_q;
        if (sync) begin
            acc_d      = sample_valid ? sample_ext_s : {AW{1'b0}};
            samp_cnt_d = sample_valid ? CW'(1) : {CW{1'b0}};
            sym_cnt_d  = {SCW{1'b0}};
            pack_d     = {(2*N){1'b0}};
        end else if (sample_valid) begin
            if (sym_done_s) begin
                acc_d      = {AW{1'b0}};
                samp_cnt_d = {CW{1'b0}};
                if (word_done_s) begin
                    sym_cnt_d = {SCW{1'b0}};
                    pack_d    = {(2*N){1'b0}};
                end else begin
                    sym_cnt_d = sym_cnt_q + SCW'(1);
                    pack_d    = pack_full_s;
                end
            end else begin
                acc_d      = sum_s;
                samp_cnt_d = samp_cnt_q + CW'(1);
            end
        end else begin
            acc_d = acc_q;
        end

        // Simultaneous hand-off lets a new word replace the one being taken.
        load_s     = word_done_s && ((state_q == ACCUM) || word_ready);
        overflow_d = word_done_s && (state_q == HOLD) && !word_ready;
        word_d     = load_s ? pack_full_s : word_q;

        state_d = state_q;
        case (state_q)
            ACCUM: begin
                if (load_s) begin
                    state_d = HOLD;
                end else begin
                    state_d = ACCUM;
                end
            end
            HOLD: begin
                if (load_s) begin
                    state_d = HOLD;
                end else if (word_ready) begin
                    state_d = ACCUM;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACCUM;
            acc_q      <= {AW{1'b0}};
            samp_cnt_q <= {CW{1'b0}};
            sym_cnt_q  <= {SCW{1'b0}};
            pack_q     <= {(2*N){1'b0}};
            word_q     <= {(2*N){1'b0}};
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            samp_cnt_q <= samp_cnt_d;
            sym_cnt_q  <= sym_cnt_d;
            pack_q     <= pack_d;
            word_q     <= word_d;
            overflow_q <= overflow_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = (state_q == HOLD);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_bpsk_symbol_packer.sv
// Randomised and directed bench for bpsk_symbol_packer against a queue-based symbol/word model.
module tb_bpsk_symbol_packer;

    localparam int N   = 8;
    localparam int SPS = 4;
    localparam int SW  = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          sync = 1'b0;
    logic [2*N-1:0] word_out;
    logic          word_valid;
    logic          word_ready = 1'b0;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    int         m_sum;
    int         m_cnt;
    logic [1:0] m_codes[$];
    logic [15:0] exp_word;
    logic        exp_valid;
    logic        exp_ovf;

    always #5 clk = ~clk;

    bpsk_symbol_packer #(.N(N), .SPS(SPS), .SW(SW)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .sync(sync), .word_out(word_out), .word_valid(word_valid),
        .word_ready(word_ready), .overflow(overflow)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        chk("word_valid", {15'd0, word_valid}, {15'd0, exp_valid});
        chk("overflow", {15'd0, overflow}, {15'd0, exp_ovf});
        chk("word_out", word_out, exp_word);
    endtask

    task automatic model_reset();
        m_sum = 0;
        m_cnt = 0;
        m_codes.delete();
        exp_word  = 16'h0000;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
    endtask

    // Behaviour for one clock edge given the inputs that were present at it.
    task automatic model_step(input logic v, input int s, input logic sy, input logic rd);
        logic        done;
        logic [15:0] w;
        done = 1'b0;
        w    = 16'h0000;
        if (sy) begin
            m_codes.delete();
            m_sum = v ? s : 0;
            m_cnt = v ? 1 : 0;
        end else if (v) begin
            m_sum += s;
            m_cnt++;
            if (m_cnt == SPS) begin
                m_codes.push_back((m_sum >= 0) ? 2'b01 : 2'b10);
                m_sum = 0;
                m_cnt = 0;
                if (m_codes.size() == N) begin
                    for (int k = 0; k < N; k++) w[2*k +: 2] = m_codes[k];
                    done = 1'b1;
                    m_codes.delete();
                end
            end
        end
        if (done) begin
            if (!exp_valid || rd) begin
                exp_word  = w;
                exp_valid = 1'b1;
                exp_ovf   = 1'b0;
            end else begin
                exp_ovf = 1'b1;
            end
        end else begin
            exp_ovf = 1'b0;
            if (exp_valid && rd) exp_valid = 1'b0;
        end
    endtask

    task automatic cycle(input logic v, input int s, input logic sy, input logic rd);
        sample_valid = v;
        sample_in    = s[SW-1:0];
        sync         = sy;
        word_ready   = rd;
        @(posedge clk);
        model_step(v, s, sy, rd);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_valid = 1'b0;
        sync = 1'b0;
        word_ready = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
        rst = 1'b0;
    endtask

    task automatic word_const(input int val, input logic rd);
        for (int i = 0; i < N * SPS; i++) cycle(1'b1, val, 1'b0, rd);
    endtask

    task automatic word_alt(input logic rd_last);
        for (int i = 0; i < N * SPS; i++)
            cycle(1'b1, ((i / SPS) % 2 == 0) ? 200 : -200, 1'b0, (i == N * SPS - 1) ? rd_last : 1'b0);
    endtask

    task automatic drain();
        cycle(1'b0, 0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_outputs();
        chk("reset_word", word_out, 16'h0000);
        rst = 1'b0;

        word_const(100, 1'b0);
        chk("pos_word", word_out, 16'h5555);
        chk("pos_valid", {15'd0, word_valid}, 16'h0001);
        cycle(1'b0, 0, 1'b0, 1'b1);
        chk("pos_taken", {15'd0, word_valid}, 16'h0000);
        drain();

        word_alt(1'b0);
        chk("alt_word", word_out, 16'h9999);
        drain();
        cycle(1'b1, 5, 1'b0, 1'b0);
        cycle(1'b1, -5, 1'b0, 1'b0);
        cycle(1'b1, 3, 1'b0, 1'b0);
        cycle(1'b1, -3, 1'b0, 1'b0);
        for (int i = SPS; i < N * SPS; i++)
            cycle(1'b1, ((i / SPS) % 2 == 0) ? 200 : -200, 1'b0, 1'b0);
        chk("zero_slot0", {14'd0, word_out[1:0]}, 16'h0001);
        chk("zero_word", word_out, 16'h9999);
        drain();

        word_const(-2048, 1'b0);
        chk("min_word", word_out, 16'hAAAA);
        drain();
        word_const(2047, 1'b0);
        chk("max_word", word_out, 16'h5555);
        drain();

        word_const(100, 1'b0);
        word_const(-100, 1'b0);
        chk("bp_ovf", {15'd0, overflow}, 16'h0001);
        chk("bp_keep", word_out, 16'h5555);
        chk("bp_valid", {15'd0, word_valid}, 16'h0001);
        cycle(1'b0, 0, 1'b0, 1'b0);
        chk("bp_ovf_once", {15'd0, overflow}, 16'h0000);
        word_alt(1'b1);
        chk("bp_third", word_out, 16'h9999);
        chk("bp_no_ovf", {15'd0, overflow}, 16'h0000);
        drain();

        cycle(1'b1, 100, 1'b0, 1'b0);
        cycle(1'b1, 100, 1'b0, 1'b0);
        cycle(1'b1, -100, 1'b1, 1'b0);
        for (int i = 0; i < N * SPS - 1; i++) cycle(1'b1, -100, 1'b0, 1'b0);
        chk("sync_word", word_out, 16'hAAAA);
        chk("sync_valid", {15'd0, word_valid}, 16'h0001);
        drain();

        for (int i = 0; i < 10; i++) cycle(1'b1, 100, 1'b0, 1'b0);
        do_reset();
        chk("rst_word", word_out, 16'h0000);
        chk("rst_valid", {15'd0, word_valid}, 16'h0000);
        word_const(100, 1'b0);
        chk("rst_after", word_out, 16'h5555);
        for (int i = 0; i < 8; i++) cycle(1'b0, 0, 1'b0, 1'b0);
        drain();

        for (int i = 0; i < 4000; i++) begin
            int s;
            s = int'($urandom_range(0, 4095)) - 2048;
            cycle($urandom_range(0, 3) != 0, s, $urandom_range(0, 199) == 0,
                  $urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
